serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial 2's-complement adder/subtractor for the ALU datapath.
//  One full_adder cell plus a carry flip-flop process one operand bit per clock, LSB first.
//  Fed by the ALU operand/opcode stage over a valid/ready handshake.
//  Drives result and flags to the ALU writeback stage over a valid/ready handshake.
//  Small-area alternative to the ripple/parallel adder path.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; legal range >= 2
//  CNT_W   $clog2(WIDTH)+1   bit-counter width; derived, do not override
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async reset, active low
//  in_valid   in   1      operands + sub valid
//  in_ready   out  1      block can accept operands
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  sub        in   1      1: A-B (A + ~B + 1); 0: A+B
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/difference (mod 2^WIDTH)
//  carry_out  out  1      carry from MSB; on sub, 1 = no borrow
//  overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero       out  1      result == 0
// BEHAVIOUR
//  FSM states: IDLE, CALC, DONE; reset state is IDLE.
//  Reset (async, rst_n=0): all output registers clear immediately.
//   - in_ready=1 (IDLE); out_valid=0; result=0; carry_out=0; overflow=0; zero=0.
//   - Bit counter, operand shift registers and carry FF clear to 0.
//  IDLE:
//   - in_ready=1.
//   - Edge with in_valid&in_ready (accept edge E0): latch op_a, op_b^{WIDTH{sub}}; carry FF<=sub; cnt<=0; ->CALC.
//  CALC:
//   - in_ready=0.
//   - Each edge feeds the full_adder: i_1=a_sh[0], i_2=b_sh[0], i_3=carry.
//   - Each edge: s shifts into result MSB (result>>1); a_sh,b_sh shift right; carry<=c; cnt++.
//   - At the edge processing bit WIDTH-1: capture carry-in of MSB (old carry) for overflow.
//   - That edge also sets carry_out<=c and ->DONE.
//  Latency: out_valid rises after edge E_WIDTH, i.e. exactly WIDTH edges after E0.
//   - Throughput: one op per WIDTH+2 cycles minimum.
//  DONE:
//   - out_valid=1; zero = (result==0).
//   - result/flags held stable until out_ready=1; then ->IDLE next edge with out_valid=0.
//   - No bypass: in_ready stays 0 in the cycle out_valid&out_ready handshakes.
//  Boundaries:
//   - in_valid while CALC/DONE: ignored, not queued.
//   - op_a/op_b changing after E0: no effect.
//   - out_ready held 0: stall forever, outputs frozen.
//   - rst_n asserted mid-CALC or DONE: partial result discarded, IDLE immediately.
//   - WIDTH not a power of 2: terminate at cnt==WIDTH-1, never by counter wrap.
//   - result/flags undefined-free: registered, only updated in CALC.
// TESTING (WIDTH=32)
//  1. add 0x0000_0005 + 0x0000_0003 -> result 0x0000_0008, carry_out 0, overflow 0, zero 0.
//     out_valid exactly 32 edges after accept.
//  2. add 0xFFFF_FFFF + 0x0000_0001 -> result 0x0000_0000, carry_out 1, overflow 0, zero 1.
//  3. sub 0x7FFF_FFFF - 0xFFFF_FFFF -> result 0x8000_0000, carry_out 0, overflow 1, zero 0.
//  4. sub 0x0000_0005 - 0x0000_0005 -> result 0, carry_out 1, overflow 0, zero 1.
//     Back-to-back: in_ready returns 1 the cycle after the out handshake.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE, pulse in_valid with new operands.
//     -> result/flags unchanged, in_ready=0, new operands never processed.
//  6. Assert rst_n=0 at bit 16 of an add -> out_valid=0, in_ready=1 immediately.
//     After release, 0x1234_5678 + 0x1111_1111 -> 0x2345_6789.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand/opcode handshake in, result/flags handshake out.
// Ports: in_valid/in_ready/op_a/op_b/sub from the operand stage,
//        out_valid/out_ready/result/carry_out/overflow/zero to writeback.
// slave = the adder/subtractor's view, master = the surrounding pipeline's view.
interface serial_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial 2's-complement add/sub, one full-adder cell + carry FF, LSB first.
// Latency: out_valid rises WIDTH edges after the accept edge; one op per WIDTH+2 cycles at best.
// Backpressure: result/flags held in DONE until out_ready; in_valid ignored while busy (no queueing).
// Ports: clk, rst_n (async, active low), bus (serial_add_sub_if.slave):
//   in_valid/in_ready/op_a/op_b/sub in, out_valid/out_ready/result/carry_out/overflow/zero out.
module serial_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_sub_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  // Full-adder cell: i_1 = a_sh[0], i_2 = b_sh[0], i_3 = carry.
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {fa_s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_q       <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Subtract as A + ~B + 1: invert B up front, seed the carry with 1.
            a_sh       <= bus.op_a;
            b_sh       <= bus.op_b ^ {WIDTH{bus.sub}};
            carry      <= bus.sub;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end

        CALC: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res_q <= res_next;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          // Terminate on an explicit compare so non-power-of-2 widths work.
          if (cnt == LAST_BIT) begin
            carry_out_q <= fa_c;
            // Old carry is the carry into the MSB on this edge.
            overflow_q  <= carry ^ fa_c;
            zero_q      <= (res_next == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          // No bypass: in_ready only returns on the edge after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized + directed bench for serial_add_sub (WIDTH=32).
// A cycle-level model (busy flag + age counter + arithmetic reference) is stepped
// every cycle on the falling edge and compared against the DUT outputs.
module tb_serial_add_sub;
  localparam int W = 32;

  logic clk;
  logic rst_n;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model state
  logic        busy;
  int          age;
  logic [34:0] cur_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {overflow, carry_out, zero, result}
  function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
    longint      sa, sb, sr;
    logic [32:0] u;
    logic [31:0] r;
    logic        c, ov, z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      r  = u[31:0];
      c  = u[32];
      sr = sa + sb;
    end
    ov = (sr != longint'($signed(r)));
    z  = (r == 32'd0);
    return {ov, c, z, r};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h7FFF_FFFF;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h0000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One model step: check what the DUT shows now, then predict the coming edge.
  task automatic monitor_step();
    logic exp_vld;
    if (!rst_n) begin
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_flags", {bus.carry_out, bus.overflow, bus.zero}, 0);
      busy = 1'b0;
      age  = 0;
    end else begin
      exp_vld = busy && (age >= W);
      chk("in_ready", bus.in_ready, !busy);
      chk("out_valid", bus.out_valid, exp_vld);
      if (exp_vld) begin
        chk("result", bus.result, cur_exp[31:0]);
        chk("zero", bus.zero, cur_exp[32]);
        chk("carry_out", bus.carry_out, cur_exp[33]);
        chk("overflow", bus.overflow, cur_exp[34]);
      end
      if (!busy) begin
        if (bus.in_valid) begin
          busy    = 1'b1;
          age     = 0;
          cur_exp = ref_op(bus.op_a, bus.op_b, bus.sub);
        end
      end else if (age >= W) begin
        if (bus.out_ready) busy = 1'b0;
      end else begin
        age++;
      end
    end
  endtask

  // Advance one cycle; inputs are changed only right after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int hold, input logic pulse,
                       output logic [31:0] r, output logic [2:0] fl);
    int n;
    int lat;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("accept_wait_bound", (n < 200), 1);
    tick();  // accept edge
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.sub      = 1'($urandom_range(0, 1));
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("latency", lat, W);
    r  = bus.result;
    fl = {bus.carry_out, bus.overflow, bus.zero};
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == hold / 2) begin
        bus.in_valid = 1'b1;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
      end
      tick();
      bus.in_valid = 1'b0;
      chk("stall_result", bus.result, r);
      chk("stall_flags", {bus.carry_out, bus.overflow, bus.zero}, fl);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("in_ready_after_handshake", bus.in_ready, 1);
    chk("out_valid_after_handshake", bus.out_valid, 0);
  endtask

  logic [31:0] r;
  logic [2:0]  fl;  // {carry_out, overflow, zero}

  initial begin
    n_cmp = 0;
    n_bad = 0;
    busy = 1'b0;
    age = 0;
    cur_exp = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;

    // Pin the reference model with hand-computed vectors.
    chk("model_add_5_3", ref_op(32'h5, 32'h3, 1'b0), {3'b000, 32'h0000_0008});
    chk("model_add_wrap", ref_op(32'hFFFF_FFFF, 32'h1, 1'b0), {3'b011, 32'h0});
    chk("model_sub_ovf", ref_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1), {3'b100, 32'h8000_0000});
    chk("model_sub_eq", ref_op(32'h5, 32'h5, 1'b1), {3'b011, 32'h0});

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1. simple add
    do_op(32'h5, 32'h3, 1'b0, 0, 1'b0, r, fl);
    chk("t1_result", r, 32'h8);
    chk("t1_flags", fl, 3'b000);
    // 2. unsigned wrap
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 0, 1'b0, r, fl);
    chk("t2_result", r, 32'h0);
    chk("t2_flags", fl, 3'b101);
    // 3. signed overflow on subtract
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, r, fl);
    chk("t3_result", r, 32'h8000_0000);
    chk("t3_flags", fl, 3'b010);
    // 4. equal operands, back to back
    do_op(32'h5, 32'h5, 1'b1, 0, 1'b0, r, fl);
    chk("t4_result", r, 32'h0);
    chk("t4_flags", fl, 3'b101);
    // 5. backpressure with an ignored in_valid pulse
    do_op(32'h0000_1000, 32'h0000_0234, 1'b0, 10, 1'b1, r, fl);
    chk("t5_result", r, 32'h0000_1234);
    chk("t5_flags", fl, 3'b000);

    // 6. reset at bit 16
    bus.op_a = 32'hAAAA_0000;
    bus.op_b = 32'h0000_5555;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();  // accept edge (in_ready is 1 here)
    bus.in_valid = 1'b0;
    repeat (16) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready_async", bus.in_ready, 1);
    chk("t6_out_valid_async", bus.out_valid, 0);
    chk("t6_result_async", bus.result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b0, r, fl);
    chk("t6_result", r, 32'h2345_6789);
    chk("t6_flags", fl, 3'b000);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int k = 0; k < 40; k++) begin
      do_op(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), r, fl);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
